slave_arbiter: RTL and testbench

- Round-robin arbiter that shares one slave memory port (req/addr/cmd/wdata/ack/rdata handshake) between N master ports.
- Sits in the cross-bar between the master-side ports and a single slave RAM.
- Serialises transactions, steers the granted master's request to the slave, and returns ack and read data to that master only.
- Adds a per-transaction timeout so that a stalled slave cannot lock the bus.

---
 rtl/xbar_pkg.sv | 18 +
 rtl/rr_pick.sv | 34 +++
 rtl/slave_arbiter.sv | 140 ++++++++++++++
 tb/tb_slave_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// Shared cross-bar definitions: arbiter state encoding, command codes and
// default bus widths used by every slave port of the cross-bar.
package xbar_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    RESP  = 2'd2,
    ABORT = 2'd3
  } arb_state_e;

  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;

  localparam int DEFAULT_AW = 32;
  localparam int DEFAULT_DW = 32;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: finds the first set request bit strictly after the
// pointer, wrapping around, so the last winner has the lowest priority.
module rr_pick
  import xbar_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW-1:0] cand;

  // Walk ptr+1 .. ptr+N (mod N) and latch the first requester found.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    grant[idx] = found;
  end

endmodule

// File: rtl/slave_arbiter.sv
// Round-robin arbiter sharing one slave memory port between N masters,
// with a per-transaction timeout so a stalled slave cannot lock the bus.
module slave_arbiter
  import xbar_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int AW        = DEFAULT_AW,
  parameter int DW        = DEFAULT_DW,
  parameter int TIMEOUT   = 64,
  localparam int IW       = $clog2(N_MASTERS),
  localparam int CW       = $clog2(TIMEOUT)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_MASTERS-1:0]    m_req,
  input  logic [N_MASTERS*AW-1:0] m_addr,
  input  logic [N_MASTERS-1:0]    m_cmd,
  input  logic [N_MASTERS*DW-1:0] m_wdata,
  output logic [N_MASTERS-1:0]    m_ack,
  output logic [N_MASTERS-1:0]    m_err,
  output logic [DW-1:0]           m_rdata,
  output logic                    s_req,
  output logic [AW-1:0]           s_addr,
  output logic                    s_cmd,
  output logic [DW-1:0]           s_wdata,
  input  logic                    s_ack,
  input  logic [DW-1:0]           s_rdata,
  output logic                    busy,
  output logic [IW-1:0]           grant_id
);

  arb_state_e           state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        grant_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [N_MASTERS-1:0] ack_d, err_d;
  logic [DW-1:0]        rdata_d;
  logic [N_MASTERS-1:0] eligible;
  logic [N_MASTERS-1:0] pick_grant;
  logic [IW-1:0]        pick_idx;

  // The master being acknowledged still holds req this cycle; hide it.
  assign eligible = m_req & ~m_ack;

  rr_pick #(
    .N  (N_MASTERS),
    .IW (IW)
  ) u_pick (
    .req   (eligible),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  assign s_req = (state_q == BUSY);
  assign busy  = (state_q != IDLE);

  // Steer the granted master's held request fields onto the slave port.
  always_comb begin
    s_addr  = '0;
    s_cmd   = CMD_READ;
    s_wdata = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (grant_id == IW'(i)) begin
        s_addr  = m_addr[i*AW +: AW];
        s_cmd   = m_cmd[i];
        s_wdata = m_wdata[i*DW +: DW];
      end
    end
  end

  // Next-state and response logic; ack/err default low so they pulse once.
  always_comb begin
    state_d = state_q;
    grant_d = grant_id;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    err_d   = '0;
    rdata_d = m_rdata;
    case (state_q)
      IDLE: begin
        if (|pick_grant) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (s_ack) begin
          cnt_d   = '0;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          cnt_d   = '0;
          state_d = ABORT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        ack_d[grant_id] = 1'b1;
        if (s_cmd == CMD_READ) begin
          rdata_d = s_rdata;
        end
        ptr_d   = grant_id;
        state_d = IDLE;
      end
      ABORT: begin
        ack_d[grant_id] = 1'b1;
        err_d[grant_id] = 1'b1;
        rdata_d         = '0;
        ptr_d           = grant_id;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and response registers; pointer resets so master 0 wins first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_id <= '0;
      ptr_q    <= IW'(N_MASTERS - 1);
      cnt_q    <= '0;
      m_ack    <= '0;
      m_err    <= '0;
      m_rdata  <= '0;
    end else begin
      state_q  <= state_d;
      grant_id <= grant_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      m_ack    <= ack_d;
      m_err    <= err_d;
      m_rdata  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_slave_arbiter.sv
// Self-checking bench for slave_arbiter: per-master command queues drive the
// masters, a slave RAM model answers with programmable wait states, and a
// scoreboard of expected transactions is checked as the DUT responds.
module tb_slave_arbiter;
  import xbar_pkg::*;

  localparam int NM      = 2;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 64;
  localparam logic [AW-1:0] HANG_ADDR = 32'h0000_003C;

  logic             clk;
  logic             reset;
  logic [NM-1:0]    m_req;
  logic [NM*AW-1:0] m_addr;
  logic [NM-1:0]    m_cmd;
  logic [NM*DW-1:0] m_wdata;
  logic [NM-1:0]    m_ack;
  logic [NM-1:0]    m_err;
  logic [DW-1:0]    m_rdata;
  logic             s_req;
  logic [AW-1:0]    s_addr;
  logic             s_cmd;
  logic [DW-1:0]    s_wdata;
  logic             s_ack;
  logic [DW-1:0]    s_rdata;
  logic             busy;
  logic [0:0]       grant_id;

  typedef struct {
    logic          cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct {
    int            master;
    logic          cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
    int            busy_len;
  } exp_t;

  cmd_t cmd_q0[$];
  cmd_t cmd_q1[$];
  exp_t sb_q[$];

  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] smem    [logic [AW-1:0]];

  int            assert_count;
  int            fail_count;
  int            pushed_count;
  int            episode_count;
  int            slave_delay;
  int            wait_cnt;
  int            run_len;
  bit            hang_en;
  bit            acked;
  bit            prev_sreq;
  logic [NM-1:0] ack_seen;
  logic [DW-1:0] model_rdata;

  slave_arbiter #(
    .N_MASTERS (NM),
    .AW        (AW),
    .DW        (DW),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .m_req    (m_req),
    .m_addr   (m_addr),
    .m_cmd    (m_cmd),
    .m_wdata  (m_wdata),
    .m_ack    (m_ack),
    .m_err    (m_err),
    .m_rdata  (m_rdata),
    .s_req    (s_req),
    .s_addr   (s_addr),
    .s_cmd    (s_cmd),
    .s_wdata  (s_wdata),
    .s_ack    (s_ack),
    .s_rdata  (s_rdata),
    .busy     (busy),
    .grant_id (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Queue one command for a master and push its expected outcome.
  task automatic applyStimulus(input int master, input logic cmd, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata);
    cmd_t c;
    exp_t e;
    c.cmd      = cmd;
    c.addr     = addr;
    c.wdata    = wdata;
    e.master   = master;
    e.cmd      = cmd;
    e.addr     = addr;
    e.wdata    = wdata;
    e.err      = hang_en && (addr == HANG_ADDR);
    e.busy_len = e.err ? TIMEOUT : slave_delay + 2;
    if (cmd == CMD_WRITE) begin
      if (!e.err) ref_mem[addr] = wdata;
      e.rdata = '0;
    end else begin
      e.rdata = e.err ? '0 : (ref_mem.exists(addr) ? ref_mem[addr] : '0);
    end
    sb_q.push_back(e);
    pushed_count++;
    if (master == 0) cmd_q0.push_back(c);
    else cmd_q1.push_back(c);
  endtask

  // Wait (bounded) for all traffic to finish, then check episode accounting.
  task automatic waitIdle(input int budget, input string tag);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      #1;
      done = (sb_q.size() == 0) && (cmd_q0.size() == 0) && (cmd_q1.size() == 0) &&
             (m_req == '0) && (ack_seen == '0) && !busy;
    end
    checkOutput({tag, "_drained"}, done, 1);
    checkOutput({tag, "_sreq_episodes"}, episode_count, pushed_count);
  endtask

  // Master driver: hold req through the ack cycle, drop it, then load the next.
  always @(negedge clk) begin
    cmd_t c;
    bit   load;
    if (!reset) begin
      for (int i = 0; i < NM; i++) begin
        load = 1'b0;
        if (m_ack[i]) begin
          ack_seen[i] = 1'b1;
        end else if (ack_seen[i]) begin
          m_req[i]    = 1'b0;
          ack_seen[i] = 1'b0;
        end else if (!m_req[i]) begin
          if (i == 0 && cmd_q0.size() > 0) begin
            c = cmd_q0.pop_front();
            load = 1'b1;
          end else if (i == 1 && cmd_q1.size() > 0) begin
            c = cmd_q1.pop_front();
            load = 1'b1;
          end
          if (load) begin
            m_cmd[i]             = c.cmd;
            m_addr[i*AW +: AW]   = c.addr;
            m_wdata[i*DW +: DW]  = c.wdata;
            m_req[i]             = 1'b1;
          end
        end
      end
    end
  end

  // Slave RAM model: acks after slave_delay+1 BUSY cycles, data the cycle after.
  always @(negedge clk) begin
    if (reset) begin
      s_ack    = 1'b0;
      acked    = 1'b0;
      wait_cnt = 0;
    end else if (acked) begin
      acked    = 1'b0;
      s_ack    = 1'b0;
      wait_cnt = 0;
      if (s_cmd == CMD_WRITE) smem[s_addr] = s_wdata;
      else s_rdata = smem.exists(s_addr) ? smem[s_addr] : '0;
    end else if (s_req) begin
      if (!(hang_en && s_addr == HANG_ADDR)) begin
        if (wait_cnt == slave_delay + 1) begin
          s_ack = 1'b1;
          acked = 1'b1;
        end else begin
          wait_cnt++;
        end
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Monitor: check each s_req episode and each m_ack against the scoreboard.
  always @(negedge clk) begin
    exp_t          h;
    logic [DW-1:0] exp_rd;
    if (reset) begin
      prev_sreq = 1'b0;
      run_len   = 0;
    end else begin
      if (s_req) begin
        if (!prev_sreq) begin
          episode_count++;
          if (sb_q.size() == 0) begin
            checkOutput("unexpected_sreq", 1, 0);
          end else begin
            h = sb_q[0];
            checkOutput("grant_id", grant_id, h.master);
            checkOutput("s_addr", s_addr, h.addr);
            checkOutput("s_cmd", s_cmd, h.cmd);
            if (h.cmd == CMD_WRITE) checkOutput("s_wdata", s_wdata, h.wdata);
          end
        end
        run_len++;
      end else if (prev_sreq) begin
        if (sb_q.size() > 0) checkOutput("sreq_cycles", run_len, sb_q[0].busy_len);
        run_len = 0;
      end
      prev_sreq = s_req;
      if (m_ack != '0) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_ack", m_ack, 0);
        end else begin
          h      = sb_q.pop_front();
          exp_rd = (h.cmd == CMD_WRITE && !h.err) ? model_rdata : h.rdata;
          checkOutput("m_ack", m_ack, 1 << h.master);
          checkOutput("m_err", m_err, h.err ? (1 << h.master) : 0);
          checkOutput("m_rdata", m_rdata, exp_rd);
          model_rdata = exp_rd;
        end
      end
    end
  end

  // Watchdog so a stuck run still terminates.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DW-1:0] d;
    int            delays [3];
    bit            seen;

    delays        = '{0, 3, 7};
    assert_count  = 0;
    fail_count    = 0;
    pushed_count  = 0;
    episode_count = 0;
    slave_delay   = 0;
    hang_en       = 1'b0;
    ack_seen      = '0;
    model_rdata   = '0;
    reset         = 1'b1;
    m_req         = '0;
    m_cmd         = '0;
    m_addr        = '0;
    m_wdata       = '0;
    s_ack         = 1'b0;
    s_rdata       = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_s_req", s_req, 0);
    checkOutput("rst_m_ack", m_ack, 0);
    checkOutput("rst_m_err", m_err, 0);
    checkOutput("rst_m_rdata", m_rdata, 0);
    checkOutput("rst_grant_id", grant_id, 0);
    reset = 1'b0;

    $display("[TB] write then read, single master");
    @(posedge clk);
    #1;
    applyStimulus(0, CMD_WRITE, 32'h10, 32'hDEAD_BEEF);
    applyStimulus(0, CMD_READ, 32'h10, 32'h0);
    @(negedge clk);
    checkOutput("t1_sreq_cycle0", s_req, 0);
    @(negedge clk);
    checkOutput("t1_sreq_cycle1", s_req, 1);
    repeat (3) @(negedge clk);
    checkOutput("t1_ack_cycle4", m_ack, 2'b01);
    waitIdle(200, "t1");

    $display("[TB] stray s_ack while idle");
    @(posedge clk);
    #1 s_ack = 1'b1;
    @(posedge clk);
    #1 s_ack = 1'b0;
    @(negedge clk);
    checkOutput("stray_ack_busy", busy, 0);
    checkOutput("stray_ack_m_ack", m_ack, 0);

    $display("[TB] simultaneous first requests after reset");
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("t2_rst_rdata", m_rdata, 0);
    model_rdata = '0;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, CMD_WRITE, 32'h40, 32'h1111_2222);
    applyStimulus(1, CMD_WRITE, 32'h80, 32'h3333_4444);
    waitIdle(200, "t2");

    $display("[TB] continuous contention");
    for (int k = 0; k < 10; k++) begin
      for (int m = 0; m < NM; m++) begin
        d = $urandom;
        if (k % 2 == 0) applyStimulus(m, CMD_WRITE, 32'h100 + m * 32'h40 + (k / 2) * 4, d);
        else applyStimulus(m, CMD_READ, 32'h100 + m * 32'h40 + (k / 2) * 4, 32'h0);
      end
    end
    waitIdle(2000, "t3");

    $display("[TB] slave wait states");
    smem[32'h20]    = 32'h0000_ABCD;
    ref_mem[32'h20] = 32'h0000_ABCD;
    for (int i = 0; i < 3; i++) begin
      slave_delay = delays[i];
      applyStimulus(0, CMD_READ, 32'h20, 32'h0);
      waitIdle(200, "t4");
    end
    slave_delay = 0;

    $display("[TB] slave timeout");
    hang_en = 1'b1;
    applyStimulus(1, CMD_READ, HANG_ADDR, 32'h0);
    applyStimulus(0, CMD_READ, 32'h20, 32'h0);
    waitIdle(500, "t5");

    $display("[TB] reset mid-transaction");
    applyStimulus(0, CMD_READ, HANG_ADDR, 32'h0);
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      seen = s_req;
    end
    checkOutput("t6_reached_busy", seen, 1);
    repeat (5) @(negedge clk);
    checkOutput("t6_rdata_before", m_rdata, 32'h0000_ABCD);
    #2 reset = 1'b1;
    #1;
    checkOutput("t6_s_req", s_req, 0);
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_m_ack", m_ack, 0);
    checkOutput("t6_m_err", m_err, 0);
    checkOutput("t6_m_rdata", m_rdata, 0);
    sb_q.delete();
    cmd_q0.delete();
    cmd_q1.delete();
    m_req       = '0;
    ack_seen    = '0;
    s_ack       = 1'b0;
    acked       = 1'b0;
    wait_cnt    = 0;
    model_rdata = '0;
    hang_en     = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    applyStimulus(0, CMD_READ, 32'h10, 32'h0);
    applyStimulus(1, CMD_READ, 32'h20, 32'h0);
    waitIdle(200, "t6");

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
